// File: rtl/ast_pkg.sv
// Shared types and helpers for the Avalon-ST packet source.
package ast_pkg;

  // Width of the empty field: number of bits to count unused symbols, minimum 1.
  function automatic int unsigned ew_f(input int unsigned spb);
    return (spb <= 2) ? 1 : $clog2(spb);
  endfunction

  localparam int unsigned DB_DEF  = 8;
  localparam int unsigned SPB_DEF = 4;
  localparam int unsigned W       = DB_DEF * SPB_DEF;
  localparam int unsigned EW      = ew_f(SPB_DEF);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // One beat of the default-width stream.
  typedef struct packed {
    logic [W-1:0]  data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

endpackage

// File: rtl/ast_rl_delay.sv
// Ready history shift register: slot_o says a beat may be registered this cycle.
module ast_rl_delay #(
  parameter int unsigned STAGES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ready_i,
  output logic slot_o
);

  if (STAGES == 0) begin : g_direct
    assign slot_o = ready_i;
  end else begin : g_shift
    logic [STAGES-1:0] sr_q;
    logic [STAGES-1:0] sr_d;

    // Shift the sink ready into the history, oldest sample at the top.
    always_comb begin
      sr_d = STAGES'({sr_q, ready_i});
    end

    // History register; cleared on reset so a fresh window is needed.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) sr_q <= '0;
      else        sr_q <= sr_d;
    end

    assign slot_o = sr_q[STAGES-1];
  end

endmodule

// File: rtl/ast_packet_source.sv
// Avalon-ST packet source: one command -> one packet of incrementing symbols.
// Optional statistics counters enabled by AST_PACKET_SOURCE_STATS_EN.
module ast_packet_source
  import ast_pkg::*;
#(
  parameter int unsigned DATABITS_PER_SYMBOL = 8,
  parameter int unsigned SYMBOLS_PER_BEAT    = 4,
  parameter int unsigned READY_LATENCY       = 2,
  parameter int unsigned LEN_W               = 16
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          cmd_valid_i,
  output logic                                          cmd_ready_o,
  input  logic [LEN_W-1:0]                              cmd_len_i,
  input  logic [DATABITS_PER_SYMBOL-1:0]                cmd_seed_i,
  input  logic                                          ast_ready_i,
  output logic                                          ast_valid_o,
  output logic [DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] ast_data_o,
  output logic                                          ast_sop_o,
  output logic                                          ast_eop_o,
  output logic [ew_f(SYMBOLS_PER_BEAT)-1:0]             ast_empty_o,
  output logic                                          busy_o
`ifdef AST_PACKET_SOURCE_STATS_EN
  ,
  output logic [31:0]                                   pkt_cnt_o,
  output logic [31:0]                                   beat_cnt_o
`endif
);

  localparam int unsigned DB  = DATABITS_PER_SYMBOL;
  localparam int unsigned SPB = SYMBOLS_PER_BEAT;
  localparam int unsigned BW  = DB * SPB;
  localparam int unsigned EWL = ew_f(SPB);

  if (READY_LATENCY < 1 || READY_LATENCY > 8) begin : g_bad_rl
    $error("ast_packet_source: READY_LATENCY must be in 1..8");
  end

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [DB-1:0]    sym_q, sym_d;
  logic             valid_q, valid_d;
  logic [BW-1:0]    data_q, data_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic [EWL-1:0]   empty_q, empty_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             slot;

  ast_rl_delay #(
    .STAGES (READY_LATENCY - 1)
  ) u_rl_delay (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .ready_i (ast_ready_i),
    .slot_o  (slot)
  );

  // Next-state, beat generation and registered-output decode.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    sym_d   = sym_q;
    valid_d = 1'b0;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    empty_d = empty_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_q && (cmd_len_i != '0)) begin
          state_d = ST_SEND;
          rem_d   = cmd_len_i;
          sym_d   = cmd_seed_i;
          beat_d  = '0;
        end
      end
      ST_SEND: begin
        if (valid_q && eop_q) begin
          state_d = ST_IDLE;
        end else if (slot && (rem_q != '0)) begin
          valid_d = 1'b1;
          sop_d   = (beat_q == '0);
          eop_d   = (rem_q <= LEN_W'(SPB));
          beat_d  = beat_q + LEN_W'(1);
          sym_d   = sym_q + DB'(SPB);
          for (int unsigned j = 0; j < SPB; j++) begin
            data_d[BW-1-j*DB -: DB] = (LEN_W'(j) < rem_q) ? (sym_q + DB'(j)) : '0;
          end
          if (rem_q <= LEN_W'(SPB)) begin
            rem_d   = '0;
            empty_d = EWL'(LEN_W'(SPB) - rem_q);
          end else begin
            rem_d   = rem_q - LEN_W'(SPB);
            empty_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_SEND);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      beat_q      <= '0;
      sym_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      empty_q     <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      beat_q      <= beat_d;
      sym_q       <= sym_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      empty_q     <= empty_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign ast_valid_o = valid_q;
  assign ast_data_o  = data_q;
  assign ast_sop_o   = sop_q;
  assign ast_eop_o   = eop_q;
  assign ast_empty_o = empty_q;
  assign busy_o      = busy_q;

`ifdef AST_PACKET_SOURCE_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;

  // Count transferred beats and transferred eop beats, wrapping at 2^32.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    beat_cnt_d = beat_cnt_q;
    if (valid_q) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
      if (eop_q) pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign beat_cnt_o = beat_cnt_q;
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_ast_packet_source.sv
// Directed bench for ast_packet_source (READY_LATENCY 2 and 1 instances).
module tb_ast_packet_source;
  import ast_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_valid1;
  logic [15:0] cmd_len_i;
  logic [7:0]  cmd_seed_i;
  logic        ast_ready_i;

  logic        cmd_ready_o, ast_valid_o, ast_sop_o, ast_eop_o, busy_o;
  logic [31:0] ast_data_o;
  logic [1:0]  ast_empty_o;
  logic        cmd_ready1, valid1, sop1, eop1, busy1;
  logic [31:0] data1;
  logic [1:0]  empty1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  ast_packet_source #(.READY_LATENCY(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_len_i(cmd_len_i), .cmd_seed_i(cmd_seed_i), .ast_ready_i(ast_ready_i),
    .ast_valid_o(ast_valid_o), .ast_data_o(ast_data_o), .ast_sop_o(ast_sop_o),
    .ast_eop_o(ast_eop_o), .ast_empty_o(ast_empty_o), .busy_o(busy_o)
  );

  ast_packet_source #(.READY_LATENCY(1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid1), .cmd_ready_o(cmd_ready1),
    .cmd_len_i(cmd_len_i), .cmd_seed_i(cmd_seed_i), .ast_ready_i(ast_ready_i),
    .ast_valid_o(valid1), .ast_data_o(data1), .ast_sop_o(sop1),
    .ast_eop_o(eop1), .ast_empty_o(empty1), .busy_o(busy1)
  );

  // Output tuple: {valid, data, sop, eop, empty, busy, cmd_ready}
  logic [38:0] got0, got1;
  assign got0 = {ast_valid_o, ast_data_o, ast_sop_o, ast_eop_o, ast_empty_o, busy_o, cmd_ready_o};
  assign got1 = {valid1, data1, sop1, eop1, empty1, busy1, cmd_ready1};

  typedef struct {
    logic        cv;
    logic [15:0] len;
    logic [7:0]  seed;
    logic        rdy;
    logic        ev;
    beat_t       eb;
    logic        ebusy;
    logic        ecr;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic cv, input logic [15:0] len, input logic [7:0] seed,
                              input logic rdy, input logic ev, input logic [31:0] d,
                              input logic s, input logic e, input logic [1:0] emp,
                              input logic b, input logic cr);
    vec_t v;
    v.cv = cv; v.len = len; v.seed = seed; v.rdy = rdy; v.ev = ev;
    v.eb.data = d; v.eb.sop = s; v.eb.eop = e; v.eb.empty = emp;
    v.ebusy = b; v.ecr = cr;
    return v;
  endfunction

  function automatic logic [38:0] expo(input logic v, input logic [31:0] d, input logic s,
                                       input logic e, input logic [1:0] emp,
                                       input logic b, input logic cr);
    return {v, d, s, e, emp, b, cr};
  endfunction

  task automatic check(input string nm, input logic [38:0] got, input logic [38:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got v=%0b d=%h s=%0b e=%0b emp=%0d busy=%0b crdy=%0b, expected v=%0b d=%h s=%0b e=%0b emp=%0d busy=%0b crdy=%0b",
               nm, got[38], got[37:6], got[5], got[4], got[3:2], got[1], got[0],
               exp[38], exp[37:6], exp[5], exp[4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Rows: inputs for one cycle, then outputs expected in the following cycle.
    vecs[0]  = mk(1, 16'd8,  8'h10, 1, 0, 32'h00000000, 0, 0, 2'd0, 1, 0);
    vecs[1]  = mk(0, 16'd0,  8'h00, 1, 1, 32'h10111213, 1, 0, 2'd0, 1, 0);
    vecs[2]  = mk(0, 16'd0,  8'h00, 1, 1, 32'h14151617, 0, 1, 2'd0, 1, 0);
    vecs[3]  = mk(0, 16'd0,  8'h00, 1, 0, 32'h14151617, 0, 1, 2'd0, 0, 1);
    vecs[4]  = mk(1, 16'd5,  8'hFE, 1, 0, 32'h14151617, 0, 1, 2'd0, 1, 0);
    vecs[5]  = mk(0, 16'd0,  8'h00, 1, 1, 32'hFEFF0001, 1, 0, 2'd0, 1, 0);
    vecs[6]  = mk(0, 16'd0,  8'h00, 1, 1, 32'h02000000, 0, 1, 2'd3, 1, 0);
    vecs[7]  = mk(0, 16'd0,  8'h00, 1, 0, 32'h02000000, 0, 1, 2'd3, 0, 1);
    vecs[8]  = mk(1, 16'd16, 8'h00, 0, 0, 32'h02000000, 0, 1, 2'd3, 1, 0);
    vecs[9]  = mk(0, 16'd0,  8'h00, 1, 0, 32'h02000000, 0, 1, 2'd3, 1, 0);
    vecs[10] = mk(0, 16'd0,  8'h00, 0, 1, 32'h00010203, 1, 0, 2'd0, 1, 0);
    vecs[11] = mk(0, 16'd0,  8'h00, 1, 0, 32'h00010203, 1, 0, 2'd0, 1, 0);
    vecs[12] = mk(0, 16'd0,  8'h00, 0, 1, 32'h04050607, 0, 0, 2'd0, 1, 0);
    vecs[13] = mk(0, 16'd0,  8'h00, 1, 0, 32'h04050607, 0, 0, 2'd0, 1, 0);
    vecs[14] = mk(0, 16'd0,  8'h00, 0, 1, 32'h08090A0B, 0, 0, 2'd0, 1, 0);
    vecs[15] = mk(0, 16'd0,  8'h00, 1, 0, 32'h08090A0B, 0, 0, 2'd0, 1, 0);
    vecs[16] = mk(0, 16'd0,  8'h00, 0, 1, 32'h0C0D0E0F, 0, 1, 2'd0, 1, 0);
    vecs[17] = mk(0, 16'd0,  8'h00, 1, 0, 32'h0C0D0E0F, 0, 1, 2'd0, 0, 1);
    vecs[18] = mk(1, 16'd0,  8'h55, 1, 0, 32'h0C0D0E0F, 0, 1, 2'd0, 0, 1);
    vecs[19] = mk(0, 16'd0,  8'h00, 1, 0, 32'h0C0D0E0F, 0, 1, 2'd0, 0, 1);
    vecs[20] = mk(1, 16'd4,  8'h20, 1, 0, 32'h0C0D0E0F, 0, 1, 2'd0, 1, 0);
    vecs[21] = mk(0, 16'd0,  8'h00, 1, 1, 32'h20212223, 1, 1, 2'd0, 1, 0);
    vecs[22] = mk(0, 16'd0,  8'h00, 1, 0, 32'h20212223, 1, 1, 2'd0, 0, 1);

    rst_i = 1'b0; cmd_valid_i = 1'b0; cmd_valid1 = 1'b0;
    cmd_len_i = '0; cmd_seed_i = '0; ast_ready_i = 1'b1;
    tick(); tick();
    check("reset_rl2", got0, '0);
    check("reset_rl1", got1, '0);

    @(negedge clk_i);
    rst_i = 1'b1;
    tick(); tick();
    check("post_reset", got0, expo(0, 32'h0, 0, 0, 2'd0, 0, 1));

    // Table-driven main sequence on the READY_LATENCY=2 instance.
    for (int i = 0; i < NV; i++) begin
      cmd_valid_i = vecs[i].cv;
      cmd_len_i   = vecs[i].len;
      cmd_seed_i  = vecs[i].seed;
      ast_ready_i = vecs[i].rdy;
      tick();
      check($sformatf("row%0d", i), got0,
            expo(vecs[i].ev, vecs[i].eb.data, vecs[i].eb.sop, vecs[i].eb.eop,
                 vecs[i].eb.empty, vecs[i].ebusy, vecs[i].ecr));
    end
    cmd_valid_i = 1'b0;

    // READY_LATENCY=1: len=3 single beat, one missing ready slot first.
    cmd_valid1 = 1'b1; cmd_len_i = 16'd3; cmd_seed_i = 8'hA0; ast_ready_i = 1'b1;
    tick();
    check("rl1_accept", got1, expo(0, 32'h0, 0, 0, 2'd0, 1, 0));
    cmd_valid1 = 1'b0; ast_ready_i = 1'b0;
    tick();
    check("rl1_no_slot", got1, expo(0, 32'h0, 0, 0, 2'd0, 1, 0));
    ast_ready_i = 1'b1;
    tick();
    check("rl1_beat", got1, expo(1, 32'hA0A1A200, 1, 1, 2'd1, 1, 0));
    tick();
    check("rl1_done", got1, expo(0, 32'hA0A1A200, 1, 1, 2'd1, 0, 1));

    // Reset during beat 2 of a 4-beat packet.
    cmd_valid_i = 1'b1; cmd_len_i = 16'd16; cmd_seed_i = 8'h40; ast_ready_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    check("mid_beat0", got0, expo(1, 32'h40414243, 1, 0, 2'd0, 1, 0));
    tick();
    tick();
    check("mid_beat2", got0, expo(1, 32'h48494A4B, 0, 0, 2'd0, 1, 0));
    rst_i = 1'b0;
    #1;
    check("mid_reset_async", got0, '0);
    tick();
    rst_i = 1'b1; ast_ready_i = 1'b0;
    tick();
    check("rel_idle", got0, expo(0, 32'h0, 0, 0, 2'd0, 0, 1));
    cmd_valid_i = 1'b1; cmd_len_i = 16'd4; cmd_seed_i = 8'h60;
    tick();
    check("rel_accept", got0, expo(0, 32'h0, 0, 0, 2'd0, 1, 0));
    cmd_valid_i = 1'b0; ast_ready_i = 1'b1;
    tick();
    check("rel_no_window", got0, expo(0, 32'h0, 0, 0, 2'd0, 1, 0));
    tick();
    check("rel_beat", got0, expo(1, 32'h60616263, 1, 1, 2'd0, 1, 0));
    tick();
    check("rel_done", got0, expo(0, 32'h60616263, 1, 1, 2'd0, 0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ast_packet_source.md
Name: ast_packet_source

Overview:
- Avalon-ST source (transmitter) that generates test packets into the Avalon-ST FIFO's write side.
- Accepts a command holding a length and a seed, then emits one packet of incrementing symbols with sop/eop/empty.
- Honours the sink's ready latency: a beat is driven only when the sink's ready was asserted READY_LATENCY cycles earlier.

Parameters:
- DATABITS_PER_SYMBOL, 8, bits per symbol.
- SYMBOLS_PER_BEAT, 4, symbols per beat; W = DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT.
- READY_LATENCY, 2, sink ready latency; legal range 1..8 (elaboration error outside).
- LEN_W, 16, width of the packet length field, in symbols.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset; asynchronous, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when cmd_valid_i && cmd_ready_o.
- cmd_len_i  in  LEN_W  packet length in symbols.
- cmd_seed_i  in  DATABITS_PER_SYMBOL  value of the first symbol.
- ast_ready_i  in  1  sink ready.
- ast_valid_o  out  1  beat valid (registered).
- ast_data_o  out  W  beat data; symbol 0 in the MSBs.
- ast_sop_o  out  1  start of packet.
- ast_eop_o  out  1  end of packet.
- ast_empty_o  out  EW  EW = max(1, $clog2(SYMBOLS_PER_BEAT)); unused symbols in the eop beat.
- busy_o  out  1  packet in progress.

Behaviour:
- Reset (rst_i=0, async):
  - FSM returns to IDLE; beat counter and ready history are cleared.
  - All outputs are 0 except cmd_ready_o, which is 0 while in reset and 1 from the first edge after release.
- FSM states and transitions:
  - IDLE: cmd_ready_o=1, busy_o=0. Command accepted with len>0 → SEND; len, seed and beat count are latched. Command with len=0 is accepted and dropped: state stays IDLE, no beat is driven.
  - SEND: cmd_ready_o=0, busy_o=1. The last beat transferring → IDLE in the next cycle. Minimum gap between packets: 1 cycle for the handshake plus the first registered beat.
- Ready-latency rule:
  - The source drives ast_valid_o=1 in cycle n only if ast_ready_i was 1 in cycle n-READY_LATENCY.
  - Implementation: ast_ready_i delayed by READY_LATENCY-1 registers (RL=1 uses ast_ready_i directly) feeds the registered valid.
  - Every valid beat counts as transferred. Valid is never asserted speculatively.
- Beats:
  - NB = ceil(len/SYMBOLS_PER_BEAT).
  - Symbol k of the packet = (seed + k) mod 2^DATABITS_PER_SYMBOL.
  - sop=1 on beat 0 only; eop=1 on beat NB-1 only; a single-beat packet has both set.
  - ast_empty_o = NB*SYMBOLS_PER_BEAT - len on the eop beat, 0 otherwise. Unused symbol lanes are driven 0.
- When a ready slot is missing, ast_valid_o=0, the beat counter holds, and data/sop/eop/empty hold their last values. No beat is skipped or repeated.
- Ready toggling every cycle yields beats in exactly the cycles where the delayed ready is 1.
- A ready slot that arrives after the last beat is ignored: valid stays 0 in IDLE.
- Counter widths:
  - Beat counter is LEN_W bits.
  - Symbol value arithmetic wraps at 2^DATABITS_PER_SYMBOL.
  - Maximum len is 2^LEN_W-1.
- Reset mid-packet: the packet is abandoned with no eop. After release the FSM is in IDLE and the ready history is empty, so the first beat needs a fresh READY_LATENCY window.

Optional Feature:
- Macro AST_PACKET_SOURCE_STATS_EN.
- Defined: adds outputs pkt_cnt_o[31:0] and beat_cnt_o[31:0].
  - pkt_cnt_o increments on each transferred eop beat; beat_cnt_o increments on every transferred beat.
  - Both wrap modulo 2^32, are reset to 0 by rst_i, and are never cleared otherwise.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package ast_pkg:
  - state enum typedef (IDLE, SEND);
  - EW computation function;
  - localparam W;
  - beat typedef struct {data, sop, eop, empty}.
- One sub-module: ast_rl_delay, the parameterised READY_LATENCY-1 stage ready shift register with async active-low reset. It outputs the "slot allowed next cycle" flag.

Test Plan:
- Defaults, ready held 1, cmd len=8, seed=0x10 → 2 beats starting 2 cycles after ready.
  - Beat 0: data 0x10111213, sop=1.
  - Beat 1: data 0x14151617, eop=1, empty=0.
- len=5, seed=0xFE → two beats: 0xFEFF0001 (sop=1), then 0x02000000 (eop=1, empty=3). Checks symbol wrap and lane zeroing.
- len=3, READY_LATENCY=1 → single beat 0xSS,SS+1,SS+2,00 with sop=eop=1, empty=1.
- Ready pattern 1,0,1,0… with len=16 → valid exactly where ready was 1 two cycles earlier. 4 beats in order, none lost; busy_o drops the cycle after eop.
- len=0 command → cmd_ready_o stays 1, no valid beat ever; next command len=4 sends 1 beat normally.
- rst_i low for 1 cycle during beat 2 of 4 → all outputs 0 immediately. After release, cmd_ready_o=1, no valid until ready has been seen READY_LATENCY cycles earlier; new packet starts with sop=1.
